// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver assembling LSB-first bytes into bit_width-wide samples
// with per-frame sample index and framing/timeout resynchronisation.
`timescale 1ns/1ps
module uart_sample_rx #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int BAUD        = 115_200,
   parameter int bit_width   = 26,
   parameter int N           = 256,
   parameter int TIMEOUT_CYC = 16 * (CLK_FREQ / BAUD)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 data_in,
   output logic [bit_width-1:0] sample_o,
   output logic                 sample_valid,
   output logic [$clog2(N)-1:0] sample_idx,
   output logic                 frame_done,
   output logic                 frame_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BYTES        = (bit_width + 7) / 8;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int TMO_W        = $clog2(TIMEOUT_CYC);
   localparam int BC_W         = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int IDX_W        = $clog2(N);

   localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t             state, state_nxt;
   logic               rx_meta, rx_s;
   logic [CNT_W-1:0]   clk_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift_reg;
   logic [BC_W-1:0]    byte_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [BYTES*8-1:0] word, word_ins;

   logic start_det, bit_tick, byte_ok, stop_err, tmo_hit, clk_cnt_clr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= data_in;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_det = 1'b0;
      bit_tick  = 1'b0;
      byte_ok   = 1'b0;
      stop_err  = 1'b0;
      tmo_hit   = 1'b0;
      unique case (state)
         S_IDLE: begin
            // A start edge takes priority over a simultaneous timeout
            if (!rx_s) begin
               start_det = 1'b1;
               state_nxt = S_START;
            end else if (byte_cnt != '0 && tmo_cnt == TMO_LAST) begin
               tmo_hit = 1'b1;
            end
         end
         S_START: begin
            if (clk_cnt == HALF) state_nxt = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (clk_cnt == LAST) begin
               bit_tick = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (clk_cnt == LAST) begin
               if (rx_s) begin
                  byte_ok   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  stop_err  = 1'b1;
                  state_nxt = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s && clk_cnt == LAST) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      clk_cnt_clr = (state_nxt != state) || bit_tick || (state == S_WAIT_IDLE && !rx_s);
   end

   always_comb begin
      word_ins = word;
      for (int unsigned k = 0; k < BYTES; k++)
         if (byte_cnt == BC_W'(k)) word_ins[8*k +: 8] = shift_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_cnt      <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         byte_cnt     <= '0;
         tmo_cnt      <= '0;
         word         <= '0;
         sample_o     <= '0;
         sample_valid <= 1'b0;
         sample_idx   <= '0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
         clk_cnt      <= clk_cnt_clr ? '0 : clk_cnt + 1'b1;

         if (start_det) begin
            bit_cnt <= '0;
         end else if (bit_tick) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= {rx_s, shift_reg[7:1]};
         end

         if (state == S_IDLE && byte_cnt != '0 && !start_det && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
         else
            tmo_cnt <= '0;

         if (sample_valid) sample_idx <= sample_idx + 1'b1;

         if (byte_ok) begin
            if (byte_cnt == BC_LAST) begin
               byte_cnt     <= '0;
               sample_o     <= word_ins[bit_width-1:0];
               sample_valid <= 1'b1;
               frame_done   <= (sample_idx == IDX_LAST);
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
               word     <= word_ins;
            end
         end else if (stop_err || tmo_hit) begin
            byte_cnt  <= '0;
            frame_err <= 1'b1;
         end
      end
   end

endmodule
